// File: rtl/mem_pkg.sv
// Shared memory-system types for the D$ request path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_pkg;

    // Widths of the captured D$ request; arbiter ports must not exceed these.
    localparam int DC_ADDR_W = 64;
    localparam int DC_DATA_W = 64;

    // log2(bytes) encoding for a full 64-bit access.
    localparam logic [1:0] WLEN_DWORD = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [DC_ADDR_W-1:0] addr;
        logic                 write;
        logic [DC_DATA_W-1:0] wdata;
        logic [1:0]           wlen;
        logic                 virt;
    } dc_req_t;

endpackage

// File: rtl/arb_pick.sv
// Fixed-priority pick (lowest index wins) with a starvation override mask.
// Latency: combinational.
// Backpressure: none; the caller decides when the grant is taken.
//
// Ports:
//   req_valid  - per-requester request
//   starved    - requesters that have hit their starve limit (subset of req_valid)
//   grant      - one-hot winner, zero when nothing is requested
//   grant_idx  - binary index of the winner
module arb_pick #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req_valid,
    input  logic [N-1:0]         starved,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx
);

    localparam int IDX_W = $clog2(N);

    logic [N-1:0] cand;
    logic         found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        // A starved requester pre-empts normal priority; among several
        // starved requesters the lowest index still wins.
        cand      = (|starved) ? starved : req_valid;
        for (int i = 0; i < N; i++) begin
            if (cand[i] && !found) begin
                grant[i]  = 1'b1;
                grant_idx = IDX_W'(i);
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dcache_port_arbiter.sv
// Registered, starvation-bounded arbiter sharing the single D$ request port.
// Latency: request -> dc_en 1 cycle; D$ completion -> resp pulse 0 cycles; 2-cycle gap between grants.
// Backpressure: requesters hold req_valid until their response; losers wait, bounded by STARVE_LIMIT.
//
// Ports:
//   clk, reset (async, active-low)
//   req_*      - flattened per-requester request fields (port 0 = PTW, port 1 = LSU)
//   resp_*     - one-hot completions routed to the owner; resp_rdata shared
//   dc_*       - D$ request port (outputs) and completions (inputs)
//   busy/owner - arbiter status
module dcache_port_arbiter
    import mem_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int STARVE_LIMIT = 8,
    parameter int ADDR_WIDTH   = 64,
    parameter int DATA_WIDTH   = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    input  logic [NUM_REQ*2-1:0]          req_wlen,
    input  logic [NUM_REQ-1:0]            req_virtual,
    output logic [NUM_REQ-1:0]            resp_rvalid,
    output logic [NUM_REQ-1:0]            resp_write_done,
    output logic [DATA_WIDTH-1:0]         resp_rdata,
    output logic                          dc_en,
    output logic [ADDR_WIDTH-1:0]         dc_addr,
    output logic                          dc_write_en,
    output logic [DATA_WIDTH-1:0]         dc_wdata,
    output logic [1:0]                    dc_wlen,
    output logic                          dc_virtual_en,
    input  logic                          dc_rvalid,
    input  logic [DATA_WIDTH-1:0]         dc_rdata,
    input  logic                          dc_write_done,
    output logic                          busy,
    output logic [$clog2(NUM_REQ)-1:0]    owner
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    arb_state_t           state, state_nxt;
    dc_req_t              cap, cap_nxt;
    logic [CNT_W-1:0]     starve_cnt [NUM_REQ];
    logic [NUM_REQ-1:0]   starved;
    logic [NUM_REQ-1:0]   pick_grant;
    logic [IDX_W-1:0]     pick_idx;
    logic                 grant_now;
    logic                 dc_done;
    int                   sel;

    // ------------------------------------------------------------------
    // Winner selection
    // ------------------------------------------------------------------
    always_comb begin
        starved = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            starved[i] = req_valid[i] && (starve_cnt[i] == CNT_W'(STARVE_LIMIT));
        end
    end

    arb_pick #(
        .N (NUM_REQ)
    ) u_pick (
        .req_valid (req_valid),
        .starved   (starved),
        .grant     (pick_grant),
        .grant_idx (pick_idx)
    );

    assign grant_now = (state == IDLE) && (|req_valid);
    assign dc_done   = dc_rvalid || dc_write_done;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|req_valid) state_nxt = BUSY;
            BUSY:    if (dc_done)    state_nxt = RELEASE;
            // One cycle with dc_en low so D$ sees a fresh request edge.
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Request capture, owner and starvation counters (updated at grant only)
    // ------------------------------------------------------------------
    always_comb begin
        sel           = int'(pick_idx);
        cap_nxt       = '0;
        cap_nxt.addr  = DC_ADDR_W'(req_addr[sel*ADDR_WIDTH +: ADDR_WIDTH]);
        cap_nxt.write = req_write[sel];
        cap_nxt.wdata = DC_DATA_W'(req_wdata[sel*DATA_WIDTH +: DATA_WIDTH]);
        cap_nxt.wlen  = req_wlen[sel*2 +: 2];
        cap_nxt.virt  = req_virtual[sel];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap   <= '0;
            owner <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                starve_cnt[i] <= '0;
            end
        end else if (grant_now) begin
            cap   <= cap_nxt;
            owner <= pick_idx;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_valid[i] || pick_grant[i]) begin
                    starve_cnt[i] <= '0;
                end else if (starve_cnt[i] != CNT_W'(STARVE_LIMIT)) begin
                    starve_cnt[i] <= starve_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // D$ port: driven purely from captured state, so it is stable in BUSY
    // ------------------------------------------------------------------
    assign dc_en         = (state == BUSY);
    assign dc_addr       = cap.addr[ADDR_WIDTH-1:0];
    assign dc_write_en   = cap.write;
    assign dc_wdata      = cap.wdata[DATA_WIDTH-1:0];
    assign dc_wlen       = cap.wlen;
    assign dc_virtual_en = cap.virt;
    assign busy          = (state != IDLE);

    // ------------------------------------------------------------------
    // Response routing. Completions outside BUSY are dropped. If D$ flags
    // both completions at once, the captured write flag decides which one
    // the owner sees. The owner still gets its pulse after a flush.
    // ------------------------------------------------------------------
    always_comb begin
        resp_rvalid     = '0;
        resp_write_done = '0;
        resp_rdata      = '0;
        if (state == BUSY) begin
            resp_rdata = dc_rdata;
            if (dc_rvalid && dc_write_done) begin
                if (cap.write) resp_write_done[owner] = 1'b1;
                else           resp_rvalid[owner]     = 1'b1;
            end else if (dc_rvalid) begin
                resp_rvalid[owner] = 1'b1;
            end else if (dc_write_done) begin
                resp_write_done[owner] = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Invariants
    // ------------------------------------------------------------------
    a_resp_onehot : assert property (@(posedge clk) disable iff (!reset)
        $onehot0(resp_rvalid | resp_write_done));

    a_en_only_busy : assert property (@(posedge clk) disable iff (!reset)
        (state != BUSY) |-> !dc_en);

    a_owner_stable : assert property (@(posedge clk) disable iff (!reset)
        (state == BUSY) |=> ((state != BUSY) || $stable(owner)));

endmodule

// File: tb/tb_dcache_port_arbiter.sv
module tb_dcache_port_arbiter;
    import mem_pkg::*;

    localparam int NR = 2;
    localparam int AW = 64;
    localparam int DW = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic [NR-1:0]   req_valid;
    logic [NR*AW-1:0] req_addr;
    logic [NR-1:0]   req_write;
    logic [NR*DW-1:0] req_wdata;
    logic [NR*2-1:0] req_wlen;
    logic [NR-1:0]   req_virtual;
    logic [NR-1:0]   resp_rvalid;
    logic [NR-1:0]   resp_write_done;
    logic [DW-1:0]   resp_rdata;
    logic            dc_en;
    logic [AW-1:0]   dc_addr;
    logic            dc_write_en;
    logic [DW-1:0]   dc_wdata;
    logic [1:0]      dc_wlen;
    logic            dc_virtual_en;
    logic            dc_rvalid;
    logic [DW-1:0]   dc_rdata;
    logic            dc_write_done;
    logic            busy;
    logic [0:0]      owner;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dcache_port_arbiter #(
        .NUM_REQ      (NR),
        .STARVE_LIMIT (8),
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_addr        (req_addr),
        .req_write       (req_write),
        .req_wdata       (req_wdata),
        .req_wlen        (req_wlen),
        .req_virtual     (req_virtual),
        .resp_rvalid     (resp_rvalid),
        .resp_write_done (resp_write_done),
        .resp_rdata      (resp_rdata),
        .dc_en           (dc_en),
        .dc_addr         (dc_addr),
        .dc_write_en     (dc_write_en),
        .dc_wdata        (dc_wdata),
        .dc_wlen         (dc_wlen),
        .dc_virtual_en   (dc_virtual_en),
        .dc_rvalid       (dc_rvalid),
        .dc_rdata        (dc_rdata),
        .dc_write_done   (dc_write_done),
        .busy            (busy),
        .owner           (owner)
    );

    typedef struct {
        string       nm;
        logic [1:0]  rv;
        logic        dcr;
        logic [63:0] rdata;
        logic        en;
        logic [1:0]  erv;
        logic [63:0] erdata;
        logic        ebusy;
        logic        eown;
        logic [63:0] eaddr;
        logic        chk_st;
        logic [3:0]  est1;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until dc_en is seen high just after an edge, within a cycle budget.
    task automatic wait_en(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (dc_en === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check({name, "_wait_en"}, 64'(seen), 64'd1);
    endtask

    function automatic void add(input string nm, input logic [1:0] rv, input logic dcr,
                                input logic [63:0] rdata, input logic en, input logic [1:0] erv,
                                input logic [63:0] erdata, input logic ebusy, input logic eown,
                                input logic [63:0] eaddr, input logic chk_st, input logic [3:0] est1);
        vec_t v;
        v.nm = nm; v.rv = rv; v.dcr = dcr; v.rdata = rdata; v.en = en; v.erv = erv;
        v.erdata = erdata; v.ebusy = ebusy; v.eown = eown; v.eaddr = eaddr;
        v.chk_st = chk_st; v.est1 = est1;
        vecs.push_back(v);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Single read on port 1, then simultaneous requests on ports 0 and 1.
        //    name            rv    dcr  rdata          en erv    erdata         bsy own addr          st est1
        add("rd_idle",       2'b10, 0, 64'h0,          0, 2'b00, 64'h0,          0, 0, 64'h0,        0, 0);
        add("rd_grant",      2'b10, 0, 64'h0,          1, 2'b00, 64'h0,          1, 1, 64'h8000_0010, 0, 0);
        add("rd_wait1",      2'b10, 0, 64'h0,          1, 2'b00, 64'h0,          1, 1, 64'h8000_0010, 0, 0);
        add("rd_wait2",      2'b10, 0, 64'h0,          1, 2'b00, 64'h0,          1, 1, 64'h8000_0010, 0, 0);
        add("rd_resp",       2'b10, 1, 64'hDEAD_BEEF,  1, 2'b10, 64'hDEAD_BEEF,  1, 1, 64'h8000_0010, 0, 0);
        add("rd_release",    2'b00, 0, 64'h0,          0, 2'b00, 64'h0,          1, 1, 64'h0,        0, 0);
        add("rd_idle2",      2'b00, 0, 64'h0,          0, 2'b00, 64'h0,          0, 1, 64'h0,        0, 0);
        add("sim_idle",      2'b11, 0, 64'h0,          0, 2'b00, 64'h0,          0, 1, 64'h0,        0, 0);
        add("sim_grant0",    2'b11, 0, 64'h0,          1, 2'b00, 64'h0,          1, 0, 64'h1000,     0, 0);
        add("sim_resp0",     2'b11, 1, 64'h55,         1, 2'b01, 64'h55,         1, 0, 64'h1000,     0, 0);
        add("sim_rel0",      2'b10, 0, 64'h0,          0, 2'b00, 64'h0,          1, 0, 64'h0,        0, 0);
        add("sim_arb1",      2'b10, 0, 64'h0,          0, 2'b00, 64'h0,          0, 0, 64'h0,        1, 1);
        add("sim_grant1",    2'b10, 0, 64'h0,          1, 2'b00, 64'h0,          1, 1, 64'h8000_0010, 1, 0);
        add("sim_resp1",     2'b10, 1, 64'h66,         1, 2'b10, 64'h66,         1, 1, 64'h8000_0010, 0, 0);
        add("sim_rel1",      2'b00, 0, 64'h0,          0, 2'b00, 64'h0,          1, 1, 64'h0,        0, 0);
        add("sim_idle3",     2'b00, 0, 64'h0,          0, 2'b00, 64'h0,          0, 1, 64'h0,        0, 0);

        reset         = 1'b0;
        req_valid     = '0;
        req_addr      = '0;
        req_write     = '0;
        req_wdata     = '0;
        req_wlen      = '0;
        req_virtual   = '0;
        dc_rvalid     = 1'b0;
        dc_rdata      = '0;
        dc_write_done = 1'b0;
        req_addr[0*AW +: AW] = 64'h1000;
        req_addr[1*AW +: AW] = 64'h8000_0010;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_dc_en", 64'(dc_en), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_owner", 64'(owner), 64'd0);
        check("rst_dc_addr", dc_addr, 64'd0);
        check("rst_resp", 64'({resp_rvalid, resp_write_done}), 64'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        // Table-driven cycle vectors
        foreach (vecs[i]) begin
            req_valid = vecs[i].rv;
            dc_rvalid = vecs[i].dcr;
            dc_rdata  = vecs[i].rdata;
            @(negedge clk);
            check({vecs[i].nm, "_dc_en"}, 64'(dc_en), 64'(vecs[i].en));
            check({vecs[i].nm, "_rvalid"}, 64'(resp_rvalid), 64'(vecs[i].erv));
            check({vecs[i].nm, "_wdone"}, 64'(resp_write_done), 64'd0);
            check({vecs[i].nm, "_rdata"}, resp_rdata, vecs[i].erdata);
            check({vecs[i].nm, "_busy"}, 64'(busy), 64'(vecs[i].ebusy));
            check({vecs[i].nm, "_owner"}, 64'(owner), 64'(vecs[i].eown));
            if (vecs[i].en)
                check({vecs[i].nm, "_dc_addr"}, dc_addr, vecs[i].eaddr);
            if (vecs[i].chk_st)
                check({vecs[i].nm, "_starve1"}, 64'(dut.starve_cnt[1]), 64'(vecs[i].est1));
            tick();
        end
        dc_rvalid = 1'b0;

        // Starvation: port 0 always requesting, port 1 held; port 1 wins grant 9.
        req_valid = 2'b11;
        for (int g = 1; g <= 9; g++) begin
            logic exp_own;
            exp_own = (g == 9) ? 1'b1 : 1'b0;
            wait_en($sformatf("starve_g%0d", g));
            @(negedge clk);
            check($sformatf("starve_owner_g%0d", g), 64'(owner), 64'(exp_own));
            tick();
            dc_rvalid = 1'b1;
            @(negedge clk);
            check($sformatf("starve_resp_g%0d", g), 64'(resp_rvalid), 64'(2'b01 << exp_own));
            tick();
            dc_rvalid = 1'b0;
            if (g == 9) req_valid = 2'b00;
        end
        tick();
        tick();

        // 64-bit write on port 1
        req_write   = 2'b10;
        req_addr[1*AW +: AW]  = 64'h8000_0040;
        req_wdata[1*DW +: DW] = 64'h0123_4567_89AB_CDEF;
        req_wlen[1*2 +: 2]    = WLEN_DWORD;
        req_virtual = 2'b10;
        req_valid   = 2'b10;
        wait_en("wr");
        @(negedge clk);
        check("wr_write_en", 64'(dc_write_en), 64'd1);
        check("wr_wdata", dc_wdata, 64'h0123_4567_89AB_CDEF);
        check("wr_wlen", 64'(dc_wlen), 64'd3);
        check("wr_virtual", 64'(dc_virtual_en), 64'd1);
        check("wr_addr", dc_addr, 64'h8000_0040);
        tick();
        @(negedge clk);
        check("wr_wdata_stable", dc_wdata, 64'h0123_4567_89AB_CDEF);
        tick();
        dc_write_done = 1'b1;
        @(negedge clk);
        check("wr_resp_wdone", 64'(resp_write_done), 64'(2'b10));
        check("wr_resp_rvalid", 64'(resp_rvalid), 64'd0);
        tick();
        dc_write_done = 1'b0;
        req_valid     = 2'b00;
        @(negedge clk);
        check("wr_release_en", 64'(dc_en), 64'd0);
        tick();

        // Write with both completions at once: write flag decides.
        req_valid = 2'b10;
        wait_en("wr2");
        tick();
        dc_rvalid     = 1'b1;
        dc_write_done = 1'b1;
        dc_rdata      = 64'h77;
        @(negedge clk);
        check("both_wdone", 64'(resp_write_done), 64'(2'b10));
        check("both_rvalid", 64'(resp_rvalid), 64'd0);
        tick();
        dc_rvalid     = 1'b0;
        dc_write_done = 1'b0;
        req_valid     = 2'b00;
        req_write     = 2'b00;
        req_virtual   = 2'b00;
        tick();

        // Flush: owner drops req_valid mid-BUSY
        req_addr[1*AW +: AW] = 64'h8000_0010;
        req_valid = 2'b10;
        wait_en("flush");
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        check("flush_en_hold1", 64'(dc_en), 64'd1);
        tick();
        @(negedge clk);
        check("flush_en_hold2", 64'(dc_en), 64'd1);
        tick();
        dc_rvalid = 1'b1;
        dc_rdata  = 64'hABCD;
        @(negedge clk);
        check("flush_resp", 64'(resp_rvalid), 64'(2'b10));
        check("flush_rdata", resp_rdata, 64'hABCD);
        tick();
        dc_rvalid = 1'b0;
        @(negedge clk);
        check("flush_release_en", 64'(dc_en), 64'd0);
        check("flush_release_busy", 64'(busy), 64'd1);
        tick();
        @(negedge clk);
        check("flush_idle_busy", 64'(busy), 64'd0);

        // Reset mid-BUSY
        tick();
        req_valid = 2'b10;
        wait_en("rst");
        tick();
        #2 reset = 1'b0;
        #1;
        check("rst_mid_dc_en", 64'(dc_en), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        req_valid = 2'b00;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("rst_rel_busy", 64'(busy), 64'd0);
        check("rst_rel_owner", 64'(owner), 64'd0);
        check("rst_rel_addr", dc_addr, 64'd0);
        tick();
        dc_rvalid = 1'b1;
        dc_rdata  = 64'h99;
        @(negedge clk);
        check("stray_rvalid", 64'(resp_rvalid), 64'd0);
        check("stray_wdone", 64'(resp_write_done), 64'd0);
        check("stray_rdata", resp_rdata, 64'd0);
        tick();
        dc_rvalid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
